// File: rtl/chinx_mem_arbiter.sv
// Two-requester arbiter (fetch "if" and load/store "ls") in front of the single chinx_mem32 port.
// Optional macro CHINX_ARB_RR_EN: round-robin on ties instead of ls priority with a starvation guard.
module chinx_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int OPND_W     = 3,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [OPND_W-1:0] ls_opnd,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_ce,
  output logic [OPND_W-1:0] mem_opnd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic [1:0]       state;
  logic [LAT_W-1:0] lat_cnt;
  logic             owner_ls;
  logic             grant_ls;
  logic             grant_if;
  logic             grant_any;

`ifdef CHINX_ARB_RR_EN
  logic last_ls;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_ls = 1'b0;
    if (state == ST_IDLE)
      grant_ls = ls_req && (!if_req || !last_ls);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_ls <= 1'b0;
    else if (grant_any)
      last_ls <= grant_ls;
  end
`else
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  logic [STV_W-1:0] starve_cnt;

  // ls has priority unless fetch has already been passed over STARVE_MAX times in a row.
  always_comb begin
    grant_ls = 1'b0;
    if (state == ST_IDLE)
      grant_ls = ls_req && (!if_req || (starve_cnt < STV_W'(STARVE_MAX)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_cnt <= '0;
    else if (grant_ls && if_req) begin
      if (starve_cnt < STV_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + STV_W'(1);
    end else if (grant_any)
      starve_cnt <= '0;
  end
`endif

  always_comb begin
    grant_if  = (state == ST_IDLE) && if_req && !grant_ls;
    grant_any = grant_ls || grant_if;
  end

  assign mem_ce = (state == ST_ACCESS);
  assign busy   = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lat_cnt   <= '0;
      owner_ls  <= 1'b0;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      mem_opnd  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            state    <= ST_ACCESS;
            lat_cnt  <= '0;
            owner_ls <= grant_ls;
            ls_gnt   <= grant_ls;
            if_gnt   <= grant_if;
            // Fetches are always a plain word load and never carry store data.
            mem_opnd  <= grant_ls ? ls_opnd  : '0;
            mem_addr  <= grant_ls ? ls_addr  : if_addr;
            mem_wdata <= grant_ls ? ls_wdata : '0;
          end
        end
        ST_ACCESS: begin
          lat_cnt <= lat_cnt + LAT_W'(1);
          if (lat_cnt == LAT_W'(MEM_LAT - 1))
            state <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (owner_ls) begin
            ls_rdata  <= mem_rdata;
            ls_rvalid <= 1'b1;
          end else begin
            if_rdata  <= mem_rdata;
            if_rvalid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chinx_mem_arbiter.sv
// Self-checking bench for chinx_mem_arbiter: directed scenarios plus random traffic
// compared cycle by cycle against a transaction-level schedule of expected outputs.
module tb_chinx_mem_arbiter;

  localparam int L    = 3;
  localparam int SMAX = 3;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic [2:0]  ls_opnd = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_ce;
  logic [2:0]  mem_opnd;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // expected-output schedule, indexed by cycle number
  bit          e_if_gnt [MAXC];
  bit          e_ls_gnt [MAXC];
  bit          e_ce     [MAXC];
  bit          e_busy   [MAXC];
  bit          e_if_rv  [MAXC];
  bit          e_ls_rv  [MAXC];
  logic [2:0]  e_opnd   [MAXC];
  logic [31:0] e_addr   [MAXC];
  logic [31:0] e_wdata  [MAXC];
  logic [31:0] e_rvdata [MAXC];
  logic [31:0] rd_mem   [MAXC];

  int          next_arb;
  int          starve;
  bit          last_ls;
  logic [31:0] m_if_rdata, m_ls_rdata;

  chinx_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .OPND_W(3), .MEM_LAT(L), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_opnd(ls_opnd), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_ce(mem_ce), .mem_opnd(mem_opnd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit lr,
                               input logic [2:0] lo, input logic [31:0] la, input logic [31:0] lw);
    if_req   = ir;
    if_addr  = ia;
    ls_req   = lr;
    ls_opnd  = lo;
    ls_addr  = la;
    ls_wdata = lw;
  endtask

  task automatic resetModel();
    for (int i = cyc; i < MAXC; i++) begin
      e_if_gnt[i] = 0; e_ls_gnt[i] = 0; e_ce[i] = 0; e_busy[i] = 0;
      e_if_rv[i] = 0;  e_ls_rv[i] = 0;
    end
    next_arb   = cyc;
    starve     = 0;
    last_ls    = 0;
    m_if_rdata = '0;
    m_ls_rdata = '0;
  endtask

  // A request seen while the arbiter is free at cycle c occupies the port
  // from c+1 to c+L, completes at c+L+2, and frees the arbiter at c+L+2.
  task automatic modelCycle(input int c);
    bit win_if, win_ls;
    win_if = 0;
    win_ls = 0;
    if (c < next_arb) return;
    if (c + L + 3 >= MAXC) begin
      bad++;
      $display("[TB] FAIL schedule_overflow cycle=%0d got=%0d exp<%0d", c, c + L + 3, MAXC);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] schedule overflow");
    end
    if (if_req && ls_req) begin
`ifdef CHINX_ARB_RR_EN
      if (last_ls) win_if = 1; else win_ls = 1;
`else
      if (starve >= SMAX) win_if = 1; else win_ls = 1;
`endif
    end else if (ls_req) win_ls = 1;
    else if (if_req) win_if = 1;
    if (!(win_if || win_ls)) return;
    starve  = (win_ls && if_req) ? ((starve + 1 > SMAX) ? SMAX : starve + 1) : 0;
    last_ls = win_ls;
    e_if_gnt[c+1] = win_if;
    e_ls_gnt[c+1] = win_ls;
    for (int k = 1; k <= L; k++) begin
      e_ce[c+k]    = 1;
      e_opnd[c+k]  = win_ls ? ls_opnd  : 3'd0;
      e_addr[c+k]  = win_ls ? ls_addr  : if_addr;
      e_wdata[c+k] = win_ls ? ls_wdata : 32'd0;
    end
    for (int k = 1; k <= L + 1; k++) e_busy[c+k] = 1;
    e_if_rv[c+L+2]  = win_if;
    e_ls_rv[c+L+2]  = win_ls;
    e_rvdata[c+L+2] = rd_mem[c+L+1];
    next_arb = c + L + 2;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput("if_gnt",    32'(if_gnt),    32'(e_if_gnt[cyc]));
    checkOutput("ls_gnt",    32'(ls_gnt),    32'(e_ls_gnt[cyc]));
    checkOutput("mem_ce",    32'(mem_ce),    32'(e_ce[cyc]));
    checkOutput("busy",      32'(busy),      32'(e_busy[cyc]));
    checkOutput("if_rvalid", 32'(if_rvalid), 32'(e_if_rv[cyc]));
    checkOutput("ls_rvalid", 32'(ls_rvalid), 32'(e_ls_rv[cyc]));
    if (e_if_rv[cyc]) m_if_rdata = e_rvdata[cyc];
    if (e_ls_rv[cyc]) m_ls_rdata = e_rvdata[cyc];
    checkOutput("if_rdata", if_rdata, m_if_rdata);
    checkOutput("ls_rdata", ls_rdata, m_ls_rdata);
    if (e_ce[cyc]) begin
      checkOutput("mem_opnd",  32'(mem_opnd), 32'(e_opnd[cyc]));
      checkOutput("mem_addr",  mem_addr,      e_addr[cyc]);
      checkOutput("mem_wdata", mem_wdata,     e_wdata[cyc]);
    end
    modelCycle(cyc);
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = rd_mem[cyc];
  endtask

  // Reset takes effect asynchronously: outputs must drop before any clock edge.
  task automatic holdReset(input int n);
    rst = 1'b0;
    #1;
    checkOutput("rst_mem_ce",    32'(mem_ce),    32'd0);
    checkOutput("rst_if_gnt",    32'(if_gnt),    32'd0);
    checkOutput("rst_ls_gnt",    32'(ls_gnt),    32'd0);
    checkOutput("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    checkOutput("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    checkOutput("rst_busy",      32'(busy),      32'd0);
    checkOutput("rst_mem_addr",  mem_addr,       32'd0);
    checkOutput("rst_ls_rdata",  ls_rdata,       32'd0);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      mem_rdata = rd_mem[cyc];
    end
    rst = 1'b1;
    resetModel();
  endtask

  task automatic randomDrive();
    if (e_if_gnt[cyc]) begin
      if ($urandom_range(1, 0) == 0) if_req = 0;
      if_addr = $urandom;
    end else if (if_req) begin
      if ($urandom_range(15, 0) == 0) if_req = 0;
    end else if ($urandom_range(2, 0) == 0) begin
      if_req  = 1;
      if_addr = $urandom;
    end
    if (e_ls_gnt[cyc]) begin
      if ($urandom_range(1, 0) == 0) ls_req = 0;
      ls_opnd  = 3'($urandom_range(7, 0));
      ls_addr  = $urandom;
      ls_wdata = $urandom;
    end else if (ls_req) begin
      if ($urandom_range(15, 0) == 0) ls_req = 0;
    end else if ($urandom_range(2, 0) == 0) begin
      ls_req   = 1;
      ls_opnd  = 3'($urandom_range(7, 0));
      ls_addr  = $urandom;
      ls_wdata = $urandom;
    end
  endtask

  initial begin
    #(MAXC * 20);
    bad++;
    $display("[TB] FAIL timeout cycle=%0d got=running exp=finished", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    for (int i = 0; i < MAXC; i++) rd_mem[i] = 32'hDEADBEEF;
    #2;
    holdReset(3);

    // single fetch
    applyStimulus(1, 32'h100, 0, 3'd0, 32'h0, 32'h0);
    stepCycle();
    applyStimulus(0, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    repeat (8) stepCycle();

    // single store
    applyStimulus(0, 32'h0, 1, 3'd2, 32'h40, 32'h12345678);
    stepCycle();
    applyStimulus(0, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    repeat (8) stepCycle();

    // contention with both requests held
    applyStimulus(1, 32'h200, 1, 3'd1, 32'h80, 32'h5555AAAA);
    repeat (48) stepCycle();
    applyStimulus(0, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    repeat (8) stepCycle();

    // fetch raised for one cycle during an ls access, then withdrawn
    applyStimulus(0, 32'h0, 1, 3'd0, 32'h44, 32'h0);
    stepCycle();
    applyStimulus(1, 32'h300, 0, 3'd0, 32'h0, 32'h0);
    stepCycle();
    applyStimulus(0, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    repeat (8) stepCycle();

    // reset in the middle of an ls access
    for (int i = cyc; i < MAXC; i++) rd_mem[i] = $urandom;
    applyStimulus(0, 32'h0, 1, 3'd0, 32'h48, 32'h0);
    stepCycle();
    applyStimulus(0, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    holdReset(2);
    repeat (10) stepCycle();

    // random traffic
    repeat (1500) begin
      randomDrive();
      stepCycle();
    end
    applyStimulus(0, 32'h0, 0, 3'd0, 32'h0, 32'h0);
    repeat (8) stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chinx_mem_arbiter.md
Name: chinx_mem_arbiter

Overview:
- Shares the single chinx_mem32 port between two requesters: instruction fetch (stage1, "if") and load/store (stage2, "ls").
- Sequences each access: arbitration, then memory enable for a fixed latency, then response capture.
- Arbitration is fixed priority to ls, with a starvation guard for if.
- Sits between the pipeline stages and mem32. It replaces the direct stage2-to-mem32 connection.

Parameters:
- ADDR_W, 32, address width (matches ADDR_WIDTH)
- DATA_W, 32, data width (matches DATA_WIDTH)
- OPND_W, 3, memory operand/opcode width (matches MEM_OPND_WIDTH)
- MEM_LAT, 1, cycles mem_ce is held per access; legal range >= 1
- STARVE_MAX, 3, consecutive ls grants tolerated while if_req is pending; legal range >= 1

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_rvalid  out  1  one-cycle fetch data valid
- if_rdata  out  DATA_W  fetched word
- ls_req  in  1  load/store request; held until ls_gnt
- ls_opnd  in  OPND_W  memory operation passed to mem32
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  one-cycle grant pulse to ls
- ls_rvalid  out  1  one-cycle completion pulse (load data valid / store done)
- ls_rdata  out  DATA_W  loaded word
- mem_ce  out  1  memory chip enable
- mem_opnd  out  OPND_W  operation to memory
- mem_addr  out  ADDR_W  address to memory
- mem_wdata  out  DATA_W  store data to memory
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs, latched request fields, owner, latency counter and starve_cnt clear to 0.
  - Any in-flight access is abandoned with no rvalid. Release is synchronous to the next clk edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no request is present, stay in IDLE.
  - Otherwise arbitrate combinationally, then register the winner's opnd/addr/wdata and the owner.
  - The winner's gnt is registered, so it is high in the first ACCESS cycle, for exactly one cycle.
  - Next state is ACCESS with lat_cnt=0.
- Fetch accesses drive mem_opnd = 0 (word load); the fetch requester never writes.
- Arbitration:
  - Only ls_req: ls wins. Only if_req: if wins.
  - Both requests and starve_cnt < STARVE_MAX: ls wins.
  - Both requests and starve_cnt == STARVE_MAX: if wins.
- starve_cnt updates at each grant:
  - ls granted while if_req=1: increment, saturating at STARVE_MAX.
  - if granted, or ls granted with if_req=0: clear to 0.
- ACCESS:
  - mem_ce=1, with mem_opnd/addr/wdata driven from the latched values.
  - lat_cnt increments each cycle. When lat_cnt == MEM_LAT-1, next state is RESP.
  - Requester inputs are ignored in this state.
- RESP:
  - mem_ce=0. mem_rdata is sampled on this cycle's edge into the owner's rdata register.
  - The owner's rvalid pulses one cycle later, coincident with the return to IDLE.
  - A new arbitration is evaluated in that same IDLE cycle, so rvalid and the next gnt are one cycle apart.
- rdata registers hold their value until the next response to the same requester.
- Latency: request seen in IDLE at cycle T gives gnt at T+1 and rvalid at T+MEM_LAT+2. Peak throughput is one access per MEM_LAT+2 cycles.
- Withdrawal: a request deasserted before its gnt is dropped without side effects.
- A request still high in the IDLE cycle that carries its own rvalid is treated as a new request.
- Both gnt never assert together. rvalid pulses only for the owner. mem_ce is never high outside ACCESS.

Optional Feature:
- Macro: CHINX_ARB_RR_EN.
- Defined: arbitration is strict round-robin when both requesters are pending; the winner is the requester not granted last. A last_owner flop resets to if, so ls wins the first tie. starve_cnt and STARVE_MAX are unused and removed.
- Undefined: fixed ls priority with the starvation guard, as described in Behaviour.

Test Plan:
- Reset mid-access: assert rst=0 while the FSM is in ACCESS with ls owner → mem_ce, gnt, rvalid and busy are 0 immediately; after release, no ls_rvalid for the abandoned access.
- Single fetch, MEM_LAT=1: if_req=1, if_addr=0x100 at T, mem_rdata=0xDEADBEEF → if_gnt at T+1; mem_ce=1 and mem_addr=0x100 at T+1; if_rvalid=1 and if_rdata=0xDEADBEEF at T+3.
- Single store, MEM_LAT=3: ls_opnd=store, ls_addr=0x40, ls_wdata=0x12345678 → mem_ce high for exactly 3 cycles with those values; ls_rvalid at T+5; if_rvalid stays 0.
- Contention, STARVE_MAX=3: if_req and ls_req held high continuously → grant order ls, ls, ls, if, ls, ls, ls, if…; gnt pulses are never simultaneous.
- Withdrawal: if_req high for one cycle while the FSM is in ACCESS serving ls, then dropped → no if_gnt and no if memory access.
- CHINX_ARB_RR_EN defined, both requests held → grant order ls, if, ls, if…
